// File: rtl/overcooked_pkg.sv
// rtl/overcooked_pkg.sv - shared screen-state encodings, scoring constants and score helpers
package overcooked_pkg;

    localparam logic [2:0] GS_WELCOME = 3'd0;
    localparam logic [2:0] GS_PLAY    = 3'd1;
    localparam logic [2:0] GS_END     = 3'd2;

    localparam logic [3:0] MAX_ORDERS     = 4'd4;
    localparam logic [9:0] DELIVER_POINTS = 10'd20;
    localparam logic [9:0] EXPIRE_PENALTY = 10'd10;
    localparam logic [9:0] SCORE_MAX      = 10'd999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } om_state_t;

    function automatic logic [9:0] score_add(input logic [9:0] s, input logic [9:0] pts);
        logic [10:0] sum;
        sum = {1'b0, s} + {1'b0, pts};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
    endfunction

    function automatic logic [9:0] score_sub(input logic [9:0] s);
        return (s >= EXPIRE_PENALTY) ? (s - EXPIRE_PENALTY) : 10'd0;
    endfunction

endpackage

// File: rtl/second_ticker.sv
// rtl/second_ticker.sv - game-second prescaler; tick is high on the last cycle of each second
module second_ticker #(
    parameter int TICKS_PER_SEC = 65_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    // Combinational so the owner's state update lands on the same edge the count wraps.
    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/order_manager.sv
// rtl/order_manager.sv - round timer, order queue and scoring for one game round
module order_manager
    import overcooked_pkg::*;
#(
    parameter int TICKS_PER_SEC = 65_000_000,
    parameter int GAME_SECONDS  = 150,
    parameter int ORDER_SECONDS = 30,
    parameter int SPAWN_SECONDS = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [2:0]      game_state,
    input  logic            deliver_valid,
    output logic [7:0]      time_left,
    output logic [9:0]      point_total,
    output logic [3:0]      orders,
    output logic [3:0][4:0] order_times,
    output logic            game_over
);

    localparam logic [7:0] GAME_T  = 8'(GAME_SECONDS);
    localparam logic [4:0] ORDER_T = 5'(ORDER_SECONDS);
    localparam int SW = $clog2(SPAWN_SECONDS + 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_SECONDS - 1);

    om_state_t       state, state_n;
    logic [7:0]      time_n;
    logic [9:0]      score_n;
    logic [3:0]      orders_n;
    logic [3:0][4:0] times_n;
    logic [3:0][4:0] work;
    logic [2:0]      wr;
    logic [SW-1:0]   spawn_cnt, spawn_n;
    logic            over_n;
    logic            run_live;
    logic            tick;

    assign run_live = (state == RUN) && (game_state == GS_PLAY);

    second_ticker #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_second_ticker (
        .clock  (clock),
        .reset  (reset),
        .enable (run_live),
        .clear  (state != RUN),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            time_left   <= '0;
            point_total <= '0;
            orders      <= '0;
            order_times <= '0;
            spawn_cnt   <= '0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            time_left   <= time_n;
            point_total <= score_n;
            orders      <= orders_n;
            order_times <= times_n;
            spawn_cnt   <= spawn_n;
            game_over   <= over_n;
        end
    end

    always_comb begin
        state_n  = state;
        time_n   = time_left;
        score_n  = point_total;
        orders_n = orders;
        times_n  = order_times;
        spawn_n  = spawn_cnt;
        over_n   = 1'b0;
        work     = '0;
        wr       = '0;

        case (state)
            IDLE: begin
                if (game_state == GS_PLAY) begin
                    state_n    = RUN;
                    time_n     = GAME_T;
                    score_n    = '0;
                    orders_n   = 4'd1;
                    times_n    = '0;
                    times_n[0] = ORDER_T;
                    spawn_n    = '0;
                end
            end
            RUN: begin
                if (game_state == GS_PLAY) begin
                    if (deliver_valid && (orders != 4'd0)) begin
                        score_n  = score_add(score_n, DELIVER_POINTS + {5'd0, times_n[0]});
                        times_n  = {5'd0, times_n[3:1]};
                        orders_n = orders_n - 4'd1;
                    end
                    if (tick) begin
                        time_n = time_left - 8'd1;
                        // Survivors are repacked from slot 0 so the oldest order stays first.
                        for (int i = 0; i < 4; i++) begin
                            if (4'(i) < orders_n) begin
                                if (times_n[i] > 5'd1) begin
                                    work[wr[1:0]] = times_n[i] - 5'd1;
                                    wr = wr + 3'd1;
                                end else begin
                                    score_n = score_sub(score_n);
                                end
                            end
                        end
                        times_n  = work;
                        orders_n = {1'b0, wr};
                        if (spawn_cnt == SPAWN_LAST) begin
                            spawn_n = '0;
                            if (orders_n < MAX_ORDERS) begin
                                times_n[orders_n[1:0]] = ORDER_T;
                                orders_n = orders_n + 4'd1;
                            end
                        end else begin
                            spawn_n = spawn_cnt + SW'(1);
                        end
                        if (time_left == 8'd1) begin
                            state_n = DONE;
                            over_n  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (game_state == GS_WELCOME) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
